if_id_pipe: RTL

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/if_id_pipe.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: a two-entry skid buffer between fetch and decode.
// The main register drives the decode side. The skid register catches the one
// entry that fetch can push in the same cycle decode stops consuming. Both
// handshake outputs come straight from registered state, so the stage has no
// combinational path from input to output. A saturating counter records how
// many cycles decode held back a valid entry.
module if_id_pipe #(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = {INST_W{1'b0}},
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_valid,
  output logic              if_ready,
  // decode side
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  input  logic              id_ready,
  // control / status
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Number of entries held: none, main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic                valid_w;
  logic                ready_w;
  logic                accept;
  logic                deliver;

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    valid_w = (state_q != EMPTY);
    ready_w = (state_q != FULL);
  end

  assign accept  = if_valid && ready_w;
  assign deliver = valid_w && id_ready;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides every handshake event in its cycle.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred when a case arm leaves the state unchanged.
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = BUSY;
        BUSY: begin
          if (accept && !deliver)      state_d = FULL;
          else if (deliver && !accept) state_d = EMPTY;
          else                         state_d = BUSY;
        end
        FULL:    if (deliver) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output logic: decode-side fields come from the main register.
  always_comb begin
    id_valid  = valid_w;
    if_ready  = ready_w;
    id_pc     = main_pc_q;
    id_inst   = main_inst_q;
    stall_cnt = stall_q;
  end

  // Next value of the main and skid registers for each transition.
  always_comb begin
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      skid_pc_d   = '0;
      skid_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end else if (accept) begin
            skid_pc_d   = if_pc;
            skid_inst_d = if_inst;
          end
        end
        FULL: begin
          if (deliver) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: ;
      endcase
    end
    // An empty stage always presents a zero pc and a bubble instruction.
    if (state_d == EMPTY) begin
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
    end
  end

  // Main and skid registers.
  // NOTE: the skid register is reset along with the main register so the
  // stage leaves reset in a fully known state, not just a known valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  // Back-pressure counter: a valid entry not consumed, saturating, kept across flush.
  always_comb begin
    stall_d = stall_q;
    if (valid_w && !id_ready && !flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

endmodule
